// File: rtl/key_led_seq.sv
// Key-driven LED sequencer: four active-low keys are synchronised, debounced and
// turned into press events that select a latched display mode stepped by a timer.
module key_led_seq #(
    parameter int LED_W           = 4,
    parameter int STEP_CYCLES     = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [3:0]       key,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode
);
    localparam int POS_W  = $clog2(LED_W);
    localparam int STEP_W = $clog2(STEP_CYCLES);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        MODE_IDLE = 3'd0,
        MODE_SHR  = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_ALT  = 3'd3,
        MODE_ALL  = 3'd4
    } mode_t;

    logic [3:0]        sync1_q;
    logic [3:0]        ks_q;
    logic [3:0]        kd;
    logic [3:0]        kd_dly_q;
    logic [3:0]        press_q, press_d;
    mode_t             mode_q, mode_d;
    logic [2:0]        target;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              step;
    logic [LED_W-1:0]  led_q, led_d;
    logic [LED_W-1:0]  shr_pat, shl_pat, alt_pat;

    genvar gi;

    // Per-key debounce: kd follows ks only after a full run of mismatching cycles.
    for (gi = 0; gi < 4; gi++) begin : g_db
        logic [DB_W-1:0] cnt_q, cnt_d;
        logic            kd_q, kd_d;

        always_comb begin
            cnt_d = '0;
            kd_d  = kd_q;
            if (ks_q[gi] != kd_q) begin
                if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    kd_d = ks_q[gi];
                end else begin
                    cnt_d = cnt_q + DB_W'(1);
                end
            end
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q <= '0;
                kd_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                kd_q  <= kd_d;
            end
        end

        assign kd[gi] = kd_q;
    end

    for (gi = 0; gi < LED_W; gi++) begin : g_pat
        localparam bit ODD = (gi % 2) == 1;
        assign shr_pat[gi] = (pos_q == POS_W'(LED_W - 1 - gi));
        assign shl_pat[gi] = (pos_q == POS_W'(gi));
        assign alt_pat[gi] = ODD ^ pos_q[0];
    end

    always_comb begin
        press_d = kd_dly_q & ~kd;

        // Lowest key index wins when several presses land together.
        target = 3'd4;
        if (press_q[0])      target = 3'd1;
        else if (press_q[1]) target = 3'd2;
        else if (press_q[2]) target = 3'd3;

        mode_d = mode_q;
        if (|press_q) begin
            mode_d = (mode_q == mode_t'(target)) ? MODE_IDLE : mode_t'(target);
        end

        step = (step_cnt_q == STEP_W'(STEP_CYCLES - 1));
        step_cnt_d = step ? '0 : step_cnt_q + STEP_W'(1);
        pos_d      = pos_q;
        if (step) begin
            pos_d = (pos_q == POS_W'(LED_W - 1)) ? '0 : pos_q + POS_W'(1);
        end
        // A mode change restarts the pattern and overrides a coincident step.
        if (mode_d != mode_q) begin
            step_cnt_d = '0;
            pos_d      = '0;
        end

        case (mode_q)
            MODE_SHR: led_d = shr_pat;
            MODE_SHL: led_d = shl_pat;
            MODE_ALT: led_d = alt_pat;
            MODE_ALL: led_d = '1;
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= 4'hF;
            ks_q       <= 4'hF;
            kd_dly_q   <= 4'hF;
            press_q    <= '0;
            mode_q     <= MODE_IDLE;
            step_cnt_q <= '0;
            pos_q      <= '0;
            led_q      <= '0;
        end else begin
            sync1_q    <= key;
            ks_q       <= sync1_q;
            kd_dly_q   <= kd;
            press_q    <= press_d;
            mode_q     <= mode_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            led_q      <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
endmodule
